// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the multicycle memory responder.
package mem_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned CNT_W          = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;

  typedef struct packed {
    logic                      we;
    logic [WORD_W-1:0]         addr;
    logic [WORD_W-1:0]         wdata;
    logic [BYTES_PER_WORD-1:0] be;
  } mem_req_t;

  // Rejects unaligned byte addresses and words beyond the array.
  function automatic logic addr_bad(input logic [WORD_W-1:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || (32'(addr[WORD_W-1:2]) >= 32'(depth));
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between initiator (master) and memory responder (slave).
interface mem_responder_if;
  import mem_pkg::*;

  logic                      req;
  logic                      we;
  logic [WORD_W-1:0]         addr;
  logic [WORD_W-1:0]         wdata;
  logic [BYTES_PER_WORD-1:0] be;
  logic [WORD_W-1:0]         rdata;
  logic                      ready;
  logic                      err;
  logic                      busy;

  modport master (output req, we, addr, wdata, be, input rdata, ready, err, busy);
  modport slave  (input req, we, addr, wdata, be, output rdata, ready, err, busy);

endinterface

// File: rtl/mem_responder_array.sv
// Single-port word storage with per-byte write enables and a registered read port.
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                      clk,
  input  logic                      we_i,
  input  logic                      re_i,
  input  logic [AW-1:0]             addr_i,
  input  logic [WORD_W-1:0]         wdata_i,
  input  logic [BYTES_PER_WORD-1:0] be_i,
  output logic [WORD_W-1:0]         rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < int'(BYTES_PER_WORD); i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory target: one request at a time, fixed wait states, byte-enabled writes, error flagging.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  mem_req_t          req_q, req_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              zero_q, zero_d;

  mem_req_t          cur;
  logic              cur_bad;
  logic              access;
  logic [WORD_W-1:0] arr_rdata;

  // With zero wait states the array is accessed on the acceptance edge, before the latches load.
  always_comb begin
    if (state_q == IDLE) begin
      cur = '{we: bus.we, addr: bus.addr, wdata: bus.wdata, be: bus.be};
    end else begin
      cur = req_q;
    end
    cur_bad = addr_bad(cur.addr, DEPTH);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          req_d   = cur;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    access  = (state_d == RESP) && (state_q != RESP);
    ready_d = (state_d == RESP);
    err_d   = access && cur_bad;
    busy_d  = (state_d != IDLE);
    zero_d  = zero_q;
    if (access && !cur.we) zero_d = cur_bad;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      zero_q  <= zero_d;
    end
  end

  mem_array #(.DEPTH(DEPTH)) u_array (
    .clk     (clk),
    .we_i    (access && cur.we && !cur_bad && !reset),
    .re_i    (access && !cur.we && !cur_bad && !reset),
    .addr_i  (cur.addr[AW+1:2]),
    .wdata_i (cur.wdata),
    .be_i    (cur.be),
    .rdata_o (arr_rdata)
  );

  // Rejected reads and reset both present zero without touching the array.
  assign bus.rdata = zero_q ? '0 : arr_rdata;
  assign bus.ready = ready_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder: two instances (2 and 0 wait states) checked against a cycle-level model.
module tb_mem_responder;

  localparam int unsigned D  = 64;
  localparam int unsigned W0 = 2;
  localparam int unsigned W1 = 0;

  logic clk;
  logic reset;

  mem_responder_if bus0();
  mem_responder_if bus1();

  mem_responder #(.DEPTH(D), .WAIT_CYCLES(W0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  mem_responder #(.DEPTH(D), .WAIT_CYCLES(W1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  logic        req_s [2];
  logic        we_s [2];
  logic [31:0] addr_s [2];
  logic [31:0] wdata_s [2];
  logic [3:0]  be_s [2];
  logic        ready_o [2];
  logic        err_o [2];
  logic        busy_o [2];
  logic [31:0] rdata_o [2];

  assign bus0.req = req_s[0];  assign bus1.req = req_s[1];
  assign bus0.we = we_s[0];    assign bus1.we = we_s[1];
  assign bus0.addr = addr_s[0];  assign bus1.addr = addr_s[1];
  assign bus0.wdata = wdata_s[0];  assign bus1.wdata = wdata_s[1];
  assign bus0.be = be_s[0];    assign bus1.be = be_s[1];
  assign ready_o[0] = bus0.ready;  assign ready_o[1] = bus1.ready;
  assign err_o[0] = bus0.err;      assign err_o[1] = bus1.err;
  assign busy_o[0] = bus0.busy;    assign busy_o[1] = bus1.busy;
  assign rdata_o[0] = bus0.rdata;  assign rdata_o[1] = bus1.rdata;

  int total = 0;
  int bad   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mdl [2][D];
  bit          have [2];
  int          resp_at [2];
  logic        p_we [2];
  logic [31:0] p_addr [2];
  logic [31:0] p_wd [2];
  logic [3:0]  p_be [2];
  logic [31:0] hold [2];
  bit          e_ready [2];
  bit          e_err [2];
  bit          e_busy [2];
  int          cyc;

  function automatic int wk(input int k);
    return (k == 0) ? int'(W0) : int'(W1);
  endfunction

  function automatic bit bad_addr(input logic [31:0] a);
    return (a % 4 != 0) || ((a / 4) >= D);
  endfunction

  task automatic apply(input int k);
    int idx;
    idx = int'(p_addr[k] / 4);
    if (bad_addr(p_addr[k])) begin
      if (!p_we[k]) hold[k] = 32'h0;
    end else if (p_we[k]) begin
      for (int i = 0; i < 4; i++)
        if (p_be[k][i]) mdl[k][idx][8*i +: 8] = p_wd[k][8*i +: 8];
    end else begin
      hold[k] = mdl[k][idx];
    end
  endtask

  // Outputs of the cycle that follows each edge: accept when free, respond W+1 cycles later.
  initial begin
    cyc = 0;
    for (int k = 0; k < 2; k++) begin
      have[k] = 0; hold[k] = 0; e_ready[k] = 0; e_err[k] = 0; e_busy[k] = 0; resp_at[k] = 0;
    end
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (reset) begin
          have[k] = 0; hold[k] = 0; e_ready[k] = 0; e_err[k] = 0; e_busy[k] = 0;
        end else begin
          if (have[k] && cyc > resp_at[k]) have[k] = 0;
          if (!have[k] && req_s[k]) begin
            have[k] = 1; resp_at[k] = cyc + wk(k) + 1;
            p_we[k] = we_s[k]; p_addr[k] = addr_s[k]; p_wd[k] = wdata_s[k]; p_be[k] = be_s[k];
          end
          if (have[k] && cyc == resp_at[k] - 1) apply(k);
          e_busy[k]  = have[k] && (cyc + 1 <= resp_at[k]);
          e_ready[k] = have[k] && (cyc + 1 == resp_at[k]);
          e_err[k]   = e_ready[k] && bad_addr(p_addr[k]);
        end
      end
      cyc++;
    end
  end

  // Per-cycle compare of every output of both instances.
  initial begin
    forever begin
      @(negedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        check($sformatf("u%0d ready", k), 32'(ready_o[k]), reset ? 32'h0 : 32'(e_ready[k]));
        check($sformatf("u%0d err", k),   32'(err_o[k]),   reset ? 32'h0 : 32'(e_err[k]));
        check($sformatf("u%0d busy", k),  32'(busy_o[k]),  reset ? 32'h0 : 32'(e_busy[k]));
        check($sformatf("u%0d rdata", k), rdata_o[k],      reset ? 32'h0 : hold[k]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic xact(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, output int lat, output int nbusy,
                      output logic e, output logic [31:0] rd);
    @(negedge clk); #1;
    req_s[k] = 1'b1; we_s[k] = w; addr_s[k] = a; wdata_s[k] = d; be_s[k] = b;
    lat = 0; nbusy = 0; e = 1'bx; rd = 'x;
    while (1) begin
      @(negedge clk); #1;
      lat++;
      if (lat == 1) begin
        req_s[k] = 1'b0; we_s[k] = 1'($urandom); addr_s[k] = $urandom;
        wdata_s[k] = $urandom; be_s[k] = 4'($urandom);
      end
      if (busy_o[k]) nbusy++;
      if (ready_o[k]) begin
        e = err_o[k]; rd = rdata_o[k];
        break;
      end
      if (lat >= 50) begin
        check($sformatf("u%0d ready timeout", k), 32'(lat), 32'(wk(k) + 1));
        break;
      end
    end
  endtask

  task automatic clear_mem(input int k);
    int l, nb; logic e; logic [31:0] rd;
    for (int w = 0; w < int'(D); w++) xact(k, 1'b1, 32'(w * 4), 32'h0, 4'hF, l, nb, e, rd);
  endtask

  task automatic rand_run(input int k, input int n);
    int l, nb, r; logic e; logic [31:0] rd; logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      r = int'($urandom_range(0, 9));
      a = 32'($urandom_range(0, D - 1) * 4);
      if (r == 0) a = a + 32'($urandom_range(1, 3));
      else if (r == 1) a = 32'(D * 4 + $urandom_range(0, 200) * 4);
      else if (r == 2) a = 32'hFFFF_FFFC;
      xact(k, 1'($urandom), a, $urandom, 4'($urandom), l, nb, e, rd);
    end
  endtask

  initial begin
    int l, nb, nrdy, first, prev; logic e; logic [31:0] rd;
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_s[k] = 0; we_s[k] = 0; addr_s[k] = 0; wdata_s[k] = 0; be_s[k] = 0;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("u%0d reset outs", k),
            {29'h0, ready_o[k], err_o[k], busy_o[k]} | rdata_o[k], 32'h0);
    end
    #2 reset = 1'b0;

    fork clear_mem(0); clear_mem(1); join

    // Full write then read, 2 wait states.
    xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, l, nb, e, rd);
    check("wr latency", 32'(l), 32'd3);
    check("wr err", 32'(e), 32'h0);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, l, nb, e, rd);
    check("rd data", rd, 32'hDEADBEEF);
    check("rd latency", 32'(l), 32'd3);
    check("rd busy cycles", 32'(nb), 32'd3);

    // Partial write.
    xact(0, 1'b1, 32'h20, 32'h11223344, 4'hF, l, nb, e, rd);
    xact(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, l, nb, e, rd);
    xact(0, 1'b0, 32'h20, 32'h0, 4'h0, l, nb, e, rd);
    check("partial rd", rd, 32'h11BB33DD);

    // Rejected accesses leave the array alone.
    xact(0, 1'b1, 32'(D * 4 - 4), 32'h55AA55AA, 4'hF, l, nb, e, rd);
    xact(0, 1'b0, 32'h22, 32'h0, 4'h0, l, nb, e, rd);
    check("misalign err", 32'(e), 32'h1);
    check("misalign rdata", rd, 32'h0);
    check("misalign latency", 32'(l), 32'd3);
    xact(0, 1'b1, 32'(D * 4), 32'hFFFFFFFF, 4'hF, l, nb, e, rd);
    check("range err", 32'(e), 32'h1);
    xact(0, 1'b0, 32'(D * 4 - 4), 32'h0, 4'h0, l, nb, e, rd);
    check("last word", rd, 32'h55AA55AA);
    check("last word err", 32'(e), 32'h0);

    // Empty byte-enable write.
    xact(0, 1'b1, 32'h10, 32'h0, 4'h0, l, nb, e, rd);
    check("be0 err", 32'(e), 32'h0);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, l, nb, e, rd);
    check("be0 unchanged", rd, 32'hDEADBEEF);

    // Reset while waiting on a write.
    @(negedge clk); #1;
    req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 32'h40; wdata_s[0] = 32'hCAFEF00D; be_s[0] = 4'hF;
    @(negedge clk); #1;
    req_s[0] = 1'b0;
    check("mid busy", 32'(busy_o[0]), 32'h1);
    #2 reset = 1'b1;
    #1 check("in reset outs", {29'h0, ready_o[0], err_o[0], busy_o[0]} | rdata_o[0], 32'h0);
    repeat (2) @(negedge clk);
    #1 check("held reset outs", {29'h0, ready_o[0], err_o[0], busy_o[0]} | rdata_o[0], 32'h0);
    #2 reset = 1'b0;
    nrdy = 0;
    repeat (6) begin
      @(negedge clk); #1;
      if (ready_o[0]) nrdy++;
    end
    check("no ready after reset", 32'(nrdy), 32'h0);
    xact(0, 1'b0, 32'h40, 32'h0, 4'h0, l, nb, e, rd);
    check("discarded write", rd, 32'h0);

    // Zero wait states, req held high: accept every other cycle.
    @(negedge clk); #1;
    req_s[1] = 1'b1; we_s[1] = 1'b0; addr_s[1] = 32'h0; wdata_s[1] = 32'h0; be_s[1] = 4'h0;
    nrdy = 0; first = -1; prev = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk); #1;
      if (ready_o[1]) begin
        nrdy++;
        if (first < 0) first = i;
        else check("b2b spacing", 32'(i - prev), 32'd2);
        prev = i;
      end
      if (i == 9) req_s[1] = 1'b0;
    end
    check("b2b count", 32'(nrdy), 32'd5);
    check("b2b first", 32'(first), 32'd1);

    fork rand_run(0, 40); rand_run(1, 60); join

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
